// File: rtl/reg_scan_reader.sv
// reg_scan_reader: walks a wrapping range of register-file addresses and streams
// (addr, data) beats over a valid/ready handshake.
module reg_scan_reader #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [WIDTH-1:0]  rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    localparam logic [ADDR_W:0]   NR   = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W:0]   rem;
    logic              bad;

    assign bad          = ({1'b0, start_addr} >= NR) || (count > NR);
    assign rf_read_addr = cur;
    assign busy         = state != IDLE;
    assign done         = state == DONE;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur       <= '0;
            rem       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (bad) err <= 1'b1;
                    else if (count == '0) state <= DONE;
                    else begin
                        cur   <= start_addr;
                        rem   <= count;
                        state <= READ;
                    end
                end
                READ: if (abort) state <= IDLE;
                else begin
                    out_data  <= rf_read_data;
                    out_addr  <= cur;
                    out_last  <= rem == 1;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                // abort takes priority over a same-edge handshake: the beat is dropped
                SEND: if (abort) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    rem       <= rem - 1'b1;
                    if (rem == 1) state <= DONE;
                    else begin
                        cur   <= (cur == LAST) ? '0 : cur + 1'b1;
                        state <= READ;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_scan_reader.sv
// tb_reg_scan_reader: directed checks of the register scan reader against
// hand-computed beats, pulses and timing.
module tb_reg_scan_reader;
    logic        CLK = 0;
    logic        reset = 1;
    logic        start = 0;
    logic [3:0]  start_addr = 0;
    logic [4:0]  count = 0;
    logic        abort = 0;
    logic [3:0]  rf_read_addr;
    logic [15:0] rf_read_data;
    logic        out_valid;
    logic        out_ready = 0;
    logic [15:0] out_data;
    logic [3:0]  out_addr;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] regs [16];
    int          checks = 0;
    int          errors = 0;

    reg_scan_reader dut (
        .CLK(CLK), .reset(reset), .start(start), .start_addr(start_addr),
        .count(count), .abort(abort), .rf_read_addr(rf_read_addr),
        .rf_read_data(rf_read_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;
    always_comb rf_read_data = regs[rf_read_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic start_scan(input logic [3:0] sa, input logic [4:0] cnt);
        start_addr = sa;
        count      = cnt;
        start      = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, out_valid, 1);
    endtask

    task automatic beat(input string tag, input logic [3:0] a, input logic [15:0] d, input logic l);
        wait_valid(tag);
        check({tag, "_addr"}, out_addr, a);
        check({tag, "_data"}, out_data, d);
        check({tag, "_last"}, out_last, l);
        tick();
    endtask

    initial begin
        logic saw_done;
        logic stable;
        for (int i = 0; i < 16; i++) regs[i] = 16'(i * 16'h0101 + 16'h0A00);
        regs[3] = 16'h8888;
        regs[4] = 16'h1234;
        #2;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_raddr", rf_read_addr, 0);
        #10 reset = 0;
        tick();

        // reset while a beat is waiting in SEND
        out_ready = 0;
        start_scan(4'd2, 5'd3);
        tick();
        check("t1_in_send", out_valid, 1);
        #2 reset = 1;
        #1;
        check("t1_busy", busy, 0);
        check("t1_valid", out_valid, 0);
        check("t1_raddr", rf_read_addr, 0);
        #2 reset = 0;
        saw_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            saw_done |= done;
        end
        check("t1_no_done", saw_done, 0);

        // two-beat scan with ready held high
        out_ready = 1;
        start_scan(4'd3, 5'd2);
        check("t2_busy", busy, 1);
        beat("t2_b0", 4'd3, 16'h8888, 0);
        beat("t2_b1", 4'd4, 16'h1234, 1);
        check("t2_done", done, 1);
        check("t2_done_busy", busy, 1);
        tick();
        check("t2_done_off", done, 0);
        check("t2_idle", busy, 0);

        // ready stalled while the source register changes
        regs[5]   = 16'hAAAA;
        out_ready = 0;
        start_scan(4'd5, 5'd1);
        wait_valid("t4");
        regs[5] = 16'hFFFF;
        stable  = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            stable &= out_valid && out_data == 16'hAAAA && out_addr == 4'd5 && out_last;
        end
        check("t4_stable", stable, 1);
        out_ready = 1;
        tick();
        check("t4_valid_off", out_valid, 0);
        check("t4_done", done, 1);
        tick();

        // zero-length scan and rejected start
        start_scan(4'd7, 5'd0);
        check("t5_done0", done, 1);
        check("t5_novalid", out_valid, 0);
        tick();
        check("t5_done0_off", done, 0);
        start_scan(4'd0, 5'd17);
        check("t5_err", err, 1);
        check("t5_err_busy", busy, 0);
        tick();
        check("t5_err_off", err, 0);

        // abort on the same edge as the first handshake
        start_scan(4'd0, 5'd3);
        wait_valid("t6");
        abort = 1;
        tick();
        abort = 0;
        check("t6_valid", out_valid, 0);
        check("t6_busy", busy, 0);
        saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_done |= done;
        end
        check("t6_no_done", saw_done, 0);

        // wrapping scan after the abort
        start_scan(4'd14, 5'd4);
        beat("t3_b0", 4'd14, regs[14], 0);
        beat("t3_b1", 4'd15, regs[15], 0);
        beat("t3_b2", 4'd0, regs[0], 0);
        beat("t3_b3", 4'd1, regs[1], 1);
        check("t3_done", done, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
